sysprint_queue: RTL



---
 rtl/sysprint_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sysprint_queue.sv
// sysprint_queue: FIFO between the print syscall strobe and the display, showing one value at a time.
// Define SYSPRINT_AUTOADV_EN to let a hold timer advance the display without a button press.
module sysprint_queue #(
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned DEPTH_LOG2  = 3,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic                  next,
    output logic [DATA_BITS-1:0]  show_data,
    output logic                  show_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("sysprint_queue: HOLD_CYCLES must be at least 2");
    end

    typedef enum logic [0:0] {ST_IDLE, ST_SHOW} state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];
    logic [DATA_BITS-1:0]   mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic [DATA_BITS-1:0]   show_data_q, show_data_d;
    logic                   show_valid_q, show_valid_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             drop_count_q, drop_count_d;
    logic                   next_q, next_d;

    logic adv_req, auto_adv, pop, wr_acc, drop, full_w;

`ifdef SYSPRINT_AUTOADV_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    always_comb begin
        next_d  = next;
        adv_req = next & ~next_q;
        full_w  = (count_q == FULL_CNT);

`ifdef SYSPRINT_AUTOADV_EN
        auto_adv = (hold_q == HOLD_MAX);
`else
        auto_adv = 1'b0;
`endif

        // A write never bypasses into the display: pop needs a stored entry.
        if (state_q == ST_IDLE) pop = (count_q != '0);
        else                    pop = (count_q != '0) && (adv_req || auto_adv);

        wr_acc = wr_en && (!full_w || pop);
        drop   = wr_en && full_w && !pop;

        mem_d = mem_q;
        if (wr_acc) mem_d[wr_ptr_q] = wr_data;

        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (wr_acc && !pop)      count_d = count_q + 1'b1;
        else if (!wr_acc && pop) count_d = count_q - 1'b1;

        state_d      = pop ? ST_SHOW : state_q;
        show_valid_d = show_valid_q | pop;
        show_data_d  = pop ? mem_q[rd_ptr_q] : show_data_q;

        overflow_d   = overflow_q | drop;
        drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;

`ifdef SYSPRINT_AUTOADV_EN
        hold_d = hold_q;
        if (pop)                                           hold_d = '0;
        else if (state_q == ST_SHOW && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            show_data_q  <= '0;
            show_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            next_q       <= 1'b0;
`ifdef SYSPRINT_AUTOADV_EN
            hold_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            show_data_q  <= show_data_d;
            show_valid_q <= show_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            next_q       <= next_d;
`ifdef SYSPRINT_AUTOADV_EN
            hold_q       <= hold_d;
`endif
        end
    end

    assign show_data  = show_data_q;
    assign show_valid = show_valid_q;
    assign count      = count_q;
    assign full       = full_w;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
